// File: rtl/top_design.sv
// 24-hour HH:MM:SS clock: prescaled one-second tick drives a cascaded BCD
// counter chain; each digit is decoded combinationally to active-high segments.
module top_design #(
  parameter logic [31:0] TICKS_PER_SEC = 32'd1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] seven_sec_p1,
  output logic [6:0] seven_sec_p2,
  output logic [6:0] seven_min_p1,
  output logic [6:0] seven_min_p2,
  output logic [6:0] seven_hr_p1,
  output logic [6:0] seven_hr_p2
);

  logic [31:0] r_pre;
  logic [3:0]  r_sec_u, r_sec_t, r_min_u, r_min_t, r_hr_u, r_hr_t;
  logic        w_tick;
  logic        w_sec_u_wrap, w_sec_wrap, w_min_u_wrap, w_min_wrap, w_day_end;

  assign w_tick       = (r_pre == TICKS_PER_SEC - 32'd1);
  assign w_sec_u_wrap = (r_sec_u == 4'd9);
  assign w_sec_wrap   = w_sec_u_wrap && (r_sec_t == 4'd5);
  assign w_min_u_wrap = (r_min_u == 4'd9);
  assign w_min_wrap   = w_min_u_wrap && (r_min_t == 4'd5);
  assign w_day_end    = (r_hr_t == 4'd2) && (r_hr_u == 4'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= 32'd0;
    end else if (w_tick) begin
      r_pre <= 32'd0;
    end else begin
      r_pre <= r_pre + 32'd1;
    end
  end

  // Each field only moves when every lower field is wrapping on this tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_u <= 4'd0;
      r_sec_t <= 4'd0;
      r_min_u <= 4'd0;
      r_min_t <= 4'd0;
      r_hr_u  <= 4'd0;
      r_hr_t  <= 4'd0;
    end else if (w_tick) begin
      r_sec_u <= w_sec_u_wrap ? 4'd0 : r_sec_u + 4'd1;
      if (w_sec_u_wrap) begin
        r_sec_t <= (r_sec_t == 4'd5) ? 4'd0 : r_sec_t + 4'd1;
      end
      if (w_sec_wrap) begin
        r_min_u <= w_min_u_wrap ? 4'd0 : r_min_u + 4'd1;
        if (w_min_u_wrap) begin
          r_min_t <= (r_min_t == 4'd5) ? 4'd0 : r_min_t + 4'd1;
        end
        if (w_min_wrap) begin
          if (w_day_end) begin
            r_hr_u <= 4'd0;
            r_hr_t <= 4'd0;
          end else if (r_hr_u == 4'd9) begin
            r_hr_u <= 4'd0;
            r_hr_t <= r_hr_t + 4'd1;
          end else begin
            r_hr_u <= r_hr_u + 4'd1;
          end
        end
      end
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  assign seven_sec_p1 = seg_decode(r_sec_u);
  assign seven_sec_p2 = seg_decode(r_sec_t);
  assign seven_min_p1 = seg_decode(r_min_u);
  assign seven_min_p2 = seg_decode(r_min_t);
  assign seven_hr_p1  = seg_decode(r_hr_u);
  assign seven_hr_p2  = seg_decode(r_hr_t);

endmodule

// File: tb/tb_top_design.sv
// Bench for top_design: one instance at 1 tick/s runs a full day, a second at
// 4 ticks/s checks prescaling and an asynchronous mid-period reset.
module tb_top_design;

  logic clk, rst, rst4;
  logic [6:0] s1, s2, m1, m2, h1, h2;
  logic [6:0] t_s1, t_s2, t_m1, t_m2, t_h1, t_h2;
  logic [41:0] obs1, obs4;
  logic [41:0] q1[$];
  logic [41:0] q4[$];
  logic [6:0] seg_tab [10];
  int n_cmp, n_err;
  int secs, secs4, pre4;
  bit chk;

  top_design #(.TICKS_PER_SEC(32'd1)) u_dut1 (
    .clk(clk), .rst(rst),
    .seven_sec_p1(s1), .seven_sec_p2(s2),
    .seven_min_p1(m1), .seven_min_p2(m2),
    .seven_hr_p1(h1),  .seven_hr_p2(h2)
  );

  top_design #(.TICKS_PER_SEC(32'd4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .seven_sec_p1(t_s1), .seven_sec_p2(t_s2),
    .seven_min_p1(t_m1), .seven_min_p2(t_m2),
    .seven_hr_p1(t_h1),  .seven_hr_p2(t_h2)
  );

  assign obs1 = {h2, h1, m2, m1, s2, s1};
  assign obs4 = {t_h2, t_h1, t_m2, t_m1, t_s2, t_s1};

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  function automatic logic [41:0] disp(input int s);
    int hh, mm, ss;
    hh = s / 3600;
    mm = (s / 60) % 60;
    ss = s % 60;
    return {seg_tab[hh / 10], seg_tab[hh % 10], seg_tab[mm / 10],
            seg_tab[mm % 10], seg_tab[ss / 10], seg_tab[ss % 10]};
  endfunction

  task automatic cmp(input string tag, input int step, input logic [41:0] obs,
                     input logic [41:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, step, obs, expv);
    end
  endtask

  initial begin
    logic [41:0] e;
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    n_cmp = 0; n_err = 0;
    secs = 0; secs4 = 0; pre4 = 0;
    rst = 1'b1; rst4 = 1'b1;

    #30;
    q1.push_back(42'h0 | disp(0));
    q4.push_back(disp(0));
    e = q1.pop_front(); cmp("reset_t1", 0, obs1, e);
    e = q4.pop_front(); cmp("reset_t4", 0, obs4, e);
    #20;
    rst = 1'b0; rst4 = 1'b0;

    for (int n = 1; n <= 86400; n++) begin
      @(posedge clk);
      secs = (secs + 1) % 86400;
      if (rst4) begin
        pre4 = 0; secs4 = 0;
      end else if (pre4 == 3) begin
        pre4 = 0; secs4 = secs4 + 1;
      end else begin
        pre4 = pre4 + 1;
      end
      chk = (n <= 130) || (n % 3600 == 0) || (n >= 86330);
      if (chk) begin
        q1.push_back(disp(secs));
        q4.push_back(disp(secs4));
      end
      @(negedge clk);
      if (chk) begin
        e = q1.pop_front(); cmp("time_t1", n, obs1, e);
        e = q4.pop_front(); cmp("time_t4", n, obs4, e);
      end
      if (n == 10) begin
        #5 rst4 = 1'b1;
        q4.push_back(disp(0));
        #1;
        e = q4.pop_front(); cmp("async_rst_t4", n, obs4, e);
      end
      if (n == 13) begin
        #5 rst4 = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
